// File: rtl/mul8_rr_sched.sv
// Two-requester round-robin front end for one shared iterative
// shift-add multiplier; one product in flight at a time.
module mul8_rr_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic            prio;
  logic            id_q;
  logic [PW-1:0]   a_sh;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]   cnt;

  logic            gnt0;
  logic            gnt1;
  logic            hs0;
  logic            hs1;
  logic            last;
  logic [PW-1:0]   acc_nxt;
  logic [PW-1:0]   op_a;
  logic [WIDTH-1:0] op_b;

  // Priority only breaks ties; a lone valid requester always wins.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~prio);
    gnt1 = req1_valid & (~req0_valid | prio);
    req0_ready = (state == IDLE) & ~rst & gnt0;
    req1_ready = (state == IDLE) & ~rst & gnt1;
    hs0 = req0_ready & req0_valid;
    hs1 = req1_ready & req1_valid;
  end

  always_comb begin
    op_a = {{WIDTH{1'b0}}, req0_a};
    op_b = req0_b;
    if (hs1) begin
      op_a = {{WIDTH{1'b0}}, req1_a};
      op_b = req1_b;
    end
  end

  always_comb begin
    acc_nxt = acc;
    if (b_q[0]) acc_nxt = acc + a_sh;
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      id_q       <= 1'b0;
      a_sh       <= '0;
      acc        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs0 | hs1) begin
            a_sh  <= op_a;
            b_q   <= op_b;
            acc   <= '0;
            cnt   <= '0;
            id_q  <= hs1;
            prio  <= hs0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_q  <= b_q >> 1;
          cnt  <= cnt + 1'b1;
          // Full WIDTH iterations always run, even for b == 0.
          if (last) begin
            rsp_result <= acc_nxt;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_rr_sched.sv
// Bench for mul8_rr_sched: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_mul8_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mul8_rr_sched #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        id;
    bit [7:0]  a;
    bit [7:0]  b;
    int        prod;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns at the negedge of the handshake cycle; gid=-1 on timeout.
  task automatic wait_grant(output int gid);
    gid = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gid = req1_ready ? 1 : 0;
        return;
      end
    end
  endtask

  // Call right after the handshake edge; checks latency, id and product
  // then completes the response handshake.
  task automatic finish_rsp(input string nm, input int eid, input int eprod);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    chk({nm, " latency"}, lat, 9);
    chk({nm, " id"}, rsp_id, eid);
    chk({nm, " result"}, rsp_result, eprod);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  vec_t vecs[8];

  // Reference model state for the random run
  int     mprio;
  bit     outst;
  bit     have[2];
  bit [7:0] oa[2];
  bit [7:0] ob[2];
  int     expq[2][$];
  int     issued;
  int     done_cnt;
  int     gid;
  bit [15:0] hold_res;
  bit     hold_id;
  int     bad_cnt;

  function automatic bit [7:0] rnd_op();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 8'd0;
    if (s == 1) return 8'd255;
    return 8'($urandom);
  endfunction

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0;
    req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{0, 8'd2,   8'd3,   6};
    vecs[1] = '{1, 8'd255, 8'd255, 65025};
    vecs[2] = '{0, 8'd0,   8'd77,  0};
    vecs[3] = '{1, 8'd200, 8'd0,   0};
    vecs[4] = '{0, 8'd1,   8'd1,   1};
    vecs[5] = '{1, 8'd128, 8'd2,   256};
    vecs[6] = '{0, 8'd255, 8'd1,   255};
    vecs[7] = '{1, 8'd16,  8'd16,  256};

    // Reset state, with valids held high to check ready suppression
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst rsp_result", rsp_result, 0);
    chk("rst readies", {req1_ready, req0_ready}, 0);
    do_reset();

    // Single-requester vector table
    foreach (vecs[k]) begin
      @(posedge clk); #1;
      if (vecs[k].id) begin
        req1_valid = 1'b1; req1_a = vecs[k].a; req1_b = vecs[k].b;
      end else begin
        req0_valid = 1'b1; req0_a = vecs[k].a; req0_b = vecs[k].b;
      end
      wait_grant(gid);
      chk($sformatf("vec%0d grant", k), gid, vecs[k].id);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a = 8'hA5; req0_b = 8'h5A;
      req1_a = 8'h3C; req1_b = 8'hC3;
      finish_rsp($sformatf("vec%0d", k), vecs[k].id, vecs[k].prod);
    end

    // Both valid from reset: grants 0,1,0
    do_reset();
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd7;
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd9;
    wait_grant(gid);
    chk("rr grant1", gid, 0);
    @(posedge clk); #1;
    req0_a = 8'd12; req0_b = 8'd10;
    finish_rsp("rr tx1", 0, 35);
    wait_grant(gid);
    chk("rr grant2", gid, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    finish_rsp("rr tx2", 1, 81);
    wait_grant(gid);
    chk("rr grant3", gid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    finish_rsp("rr tx3", 0, 120);

    // DONE hold with rsp_ready low for 20 cycles
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 8'd13; req1_b = 8'd11;
    wait_grant(gid);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    hold_res = rsp_result;
    hold_id = rsp_id;
    chk("hold result", hold_res, 143);
    bad_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result != hold_res || rsp_id != hold_id ||
          req0_ready || req1_ready || !busy)
        bad_cnt++;
    end
    chk("hold stable cycles", bad_cnt, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold release busy", busy, 0);
    chk("hold release ready", req0_ready | req1_ready, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset in CALC cycle 4 discards the product and clears prio
    do_reset();
    req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
    wait_grant(gid);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst busy", busy, 0);
    bad_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) bad_cnt++;
    end
    chk("midrst no stale rsp", bad_cnt, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'd11; req0_b = 8'd13;
    req1_valid = 1'b1; req1_a = 8'd6;  req1_b = 8'd7;
    wait_grant(gid);
    chk("midrst prio grant", gid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    finish_rsp("midrst tx1", 0, 143);
    wait_grant(gid);
    chk("midrst grant2", gid, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    finish_rsp("midrst tx2", 1, 42);

    // Randomized run against the reference model
    do_reset();
    mprio = 0;
    outst = 1'b0;
    have[0] = 1'b0;
    have[1] = 1'b0;
    issued = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      int   win;
      bit [1:0] exp_rdy;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!have[n] && issued < 1000 && $urandom_range(0, 3) == 0) begin
          have[n] = 1'b1;
          oa[n] = rnd_op();
          ob[n] = rnd_op();
        end
      end
      req0_valid = have[0] && ($urandom_range(0, 3) != 0);
      req1_valid = have[1] && ($urandom_range(0, 3) != 0);
      req0_a = oa[0]; req0_b = ob[0];
      req1_a = oa[1]; req1_b = ob[1];
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      win = -1;
      if (!outst) begin
        if (req0_valid && req1_valid) win = mprio;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end
      exp_rdy = (win < 0) ? 2'b00 : (win == 1 ? 2'b10 : 2'b01);
      if ({req1_ready, req0_ready} != exp_rdy) begin
        chk("rand grant", {req1_ready, req0_ready}, exp_rdy);
      end
      if (rsp_valid && !outst) chk("rand spurious rsp", 1, 0);
      if (rsp_valid && rsp_ready) begin
        int e;
        if (expq[rsp_id].size() == 0) begin
          chk("rand rsp unmatched id", rsp_id, 2);
        end else begin
          e = expq[rsp_id].pop_front();
          chk($sformatf("rand rsp%0d", done_cnt), rsp_result, e);
        end
        done_cnt++;
        outst = 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
        bit v;
        bit r;
        v = (n == 0) ? req0_valid : req1_valid;
        r = (n == 0) ? req0_ready : req1_ready;
        if (v && r) begin
          expq[n].push_back(int'(oa[n]) * int'(ob[n]));
          have[n] = 1'b0;
          outst = 1'b1;
          mprio = 1 - n;
          issued++;
        end
      end
      if (issued >= 1000 && !outst) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rand issued", issued, 1000);
    chk("rand completed", done_cnt, 1000);
    chk("rand leftover", expq[0].size() + expq[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
